// File: rtl/consmax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : consmax_pkg                                                  |
// | Description : Shared types and constants for the ConSmax LUT loader.       |
// |               - state_t        : loader FSM state encoding                 |
// |               - LUT_ADDR_DFLT  : default per-LUT address width             |
// |               - LUT_DATA_DFLT  : default LUT word width                     |
// |               - CHK_W          : checksum accumulator width                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package consmax_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default LUT geometry: 16 entries per LUT, bf16-style words.
  localparam int LUT_ADDR_DFLT = 4;
  localparam int LUT_DATA_DFLT = 16;

  // Width of the wrap-around load checksum.
  localparam int CHK_W = 16;

endpackage : consmax_pkg
`default_nettype wire

// File: rtl/consmax_lut_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : consmax_lut_chk                                              |
// | Description : Wrap-around additive checksum over the transferred LUT words.|
// |               On clr the sum is zeroed, the expected value is latched and  |
// |               the mismatch flag is cleared. On chk_eval the running sum is |
// |               compared against the latched expectation; the result stays   |
// |               until the next clr.                                          |
// | Ports       : clk       in   clock                                         |
// |               rstn      in   async active-low reset                        |
// |               clr       in   clear sum / latch exp / clear mismatch        |
// |               en        in   accumulate data this cycle                    |
// |               data      in   CHK_W word to accumulate                      |
// |               exp       in   expected checksum (sampled on clr)            |
// |               chk_eval  in   compare sum against latched expectation       |
// |               mismatch  out  registered, sticky comparison result          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module consmax_lut_chk
  import consmax_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CHK_W-1:0] data,
  input  logic [CHK_W-1:0] exp,
  input  logic             chk_eval,
  output logic             mismatch
);

  logic [CHK_W-1:0] sum;
  logic [CHK_W-1:0] exp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum      <= '0;
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else if (clr) begin
      sum      <= '0;
      exp_q    <= exp;
      mismatch <= 1'b0;
    end else begin
      // Natural CHK_W-bit overflow gives the wrap-around sum.
      if (en) begin
        sum <= sum + data;
      end
      if (chk_eval) begin
        mismatch <= (sum != exp_q);
      end
    end
  end

endmodule : consmax_lut_chk
`default_nettype wire

// File: rtl/consmax_lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : consmax_lut_loader                                           |
// | Description : Writer side of the ConSmax LUT write port. Accepts a         |
// |               valid/ready stream of LUT words, holds off the softmax       |
// |               datapath, waits DRAIN_CYC cycles for in-flight LUT reads to  |
// |               retire, then writes all 2*LUT_DEPTH entries in order         |
// |               (LUT0 then LUT1; address MSB selects LUT1).                  |
// | Build macro : CONSMAX_LUT_CHK_EN - enables the load checksum (chk_err).    |
// |               Undefined: cfg_chk ignored, chk_err tied low.                |
// | Ports       : clk        in   clock                                        |
// |               rstn       in   async active-low reset                       |
// |               start      in   load request pulse (accepted in IDLE only)   |
// |               cfg_chk    in   expected checksum, sampled on accepted start |
// |               in_data    in   LUT word stream                              |
// |               in_valid   in   in_data valid                                |
// |               in_ready   out  loader accepts in_data (state == LOAD)       |
// |               lut_waddr  out  LUT write address                            |
// |               lut_wen    out  LUT write enable                             |
// |               lut_wdata  out  LUT write data                               |
// |               dp_hold    out  hold upstream idata_valid low                |
// |               busy       out  loader not idle                              |
// |               done       out  pulse with the last entry write              |
// |               err_start  out  pulse: start seen while not idle             |
// |               chk_err    out  sticky checksum mismatch                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module consmax_lut_loader
  import consmax_pkg::*;
#(
  parameter int LUT_ADDR  = LUT_ADDR_DFLT,
  parameter int LUT_DATA  = LUT_DATA_DFLT,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [CHK_W-1:0]    cfg_chk,
  input  logic [LUT_DATA-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LUT_ADDR:0]   lut_waddr,
  output logic                lut_wen,
  output logic [LUT_DATA-1:0] lut_wdata,
  output logic                dp_hold,
  output logic                busy,
  output logic                done,
  output logic                err_start,
  output logic                chk_err
);

  // Drain counter sized to hold DRAIN_CYC-1 (at least one bit).
  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);
  // Address of the final entry across both LUTs.
  localparam logic [LUT_ADDR:0] CNT_LAST = '1;

  state_t              state;
  logic [LUT_ADDR:0]   cnt;
  logic [DCNT_W-1:0]   drain_cnt;

  logic                xfer;
  logic                start_ok;

  assign in_ready = (state == ST_LOAD);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      lut_waddr <= '0;
      lut_wen   <= 1'b0;
      lut_wdata <= '0;
      dp_hold   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_start <= 1'b0;
    end else begin
      lut_wen   <= 1'b0;
      done      <= 1'b0;
      // Any start outside IDLE (DONE included) is flagged and dropped.
      err_start <= start && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DRAIN;
            cnt       <= '0;
            drain_cnt <= '0;
            dp_hold   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        // dp_hold is already asserted; wait for reads issued before the hold
        // to propagate through idata_valid_reg -> lut_ren -> lut_rvalid.
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_LOAD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            lut_wen   <= 1'b1;
            lut_waddr <= cnt;
            lut_wdata <= in_data;
            // Wraps to 0 after the last entry.
            cnt       <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          dp_hold <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          dp_hold <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONSMAX_LUT_CHK_EN
  logic [CHK_W-1:0] chk_data;

  // Words are zero-extended or truncated to the checksum width.
  assign chk_data = CHK_W'(in_data);

  consmax_lut_chk u_chk (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (start_ok),
    .en       (xfer),
    .data     (chk_data),
    .exp      (cfg_chk),
    .chk_eval (state == ST_DONE),
    .mismatch (chk_err)
  );
`else
  logic unused_chk;

  assign unused_chk = ^{cfg_chk, start_ok};
  assign chk_err    = 1'b0;
`endif

endmodule : consmax_lut_loader
`default_nettype wire

// File: tb/tb_consmax_lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_consmax_lut_loader                                        |
// | Description : Directed self-checking bench for consmax_lut_loader with     |
// |               LUT_ADDR=4 (32 entries), LUT_DATA=16, DRAIN_CYC=3.           |
// |               Load words are 0x3F80+k, k=0..31; their 16-bit sum is       |
// |               32*0x3F80 + 496 = 0x7F1F0 -> 0xF1F0.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_consmax_lut_loader;

  localparam logic [15:0] SUM_OK = 16'hF1F0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_chk = 16'h0;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  lut_waddr;
  logic        lut_wen;
  logic [15:0] lut_wdata;
  logic        dp_hold;
  logic        busy;
  logic        done;
  logic        err_start;
  logic        chk_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  consmax_lut_loader #(
    .LUT_ADDR  (4),
    .LUT_DATA  (16),
    .DRAIN_CYC (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .cfg_chk   (cfg_chk),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lut_waddr (lut_waddr),
    .lut_wen   (lut_wen),
    .lut_wdata (lut_wdata),
    .dp_hold   (dp_hold),
    .busy      (busy),
    .done      (done),
    .err_start (err_start),
    .chk_err   (chk_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full load from IDLE. toggle: in_valid alternates 1,0,...; err_at: entry
  // index at which a stray start is pulsed (-1 none); start_in_done: pulse a
  // stray start in the DONE cycle; chk: cfg_chk presented with start.
  task automatic run_load(input bit toggle, input int err_at,
                          input bit start_in_done, input logic [15:0] chk);
    logic [26:0] exp_v;
    logic [26:0] obs_v;
    logic [4:0]  last_a;
    logic [15:0] last_d;
    bit          err_done;
    bit          err_now;
    bit          exp_chk;
    int          k;

    last_a   = 5'd0;
    last_d   = 16'h0;
    err_done = 1'b0;
    k        = 0;

    cfg_chk  = chk;
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cfg_chk  = 16'h0;

    checks++;
    if ({busy, dp_hold, in_ready, chk_err, lut_wen} !== 5'b11000) begin
      errors++;
      $display("FAIL drain_entry: busy/hold/ready/chk_err/wen got %b want 11000",
               {busy, dp_hold, in_ready, chk_err, lut_wen});
    end
    repeat (2) begin
      tick();
      checks++;
      if ({busy, dp_hold, in_ready, lut_wen} !== 4'b1100) begin
        errors++;
        $display("FAIL drain_hold: busy/hold/ready/wen got %b want 1100",
                 {busy, dp_hold, in_ready, lut_wen});
      end
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: in_ready got %b want 1", in_ready);
    end

    for (int cyc = 0; cyc < 200 && k < 32; cyc++) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = 16'h3F80 + 16'(k);
      start    = (k == err_at) && !err_done;
      err_now  = start;
      if (start) err_done = 1'b1;
      tick();
      start = 1'b0;
      if (in_valid) begin
        last_a = k[4:0];
        last_d = in_data;
        k++;
      end
      exp_v = {in_valid, (in_valid && k == 32), (k != 32), 1'b1, 1'b1, err_now,
               last_a, last_d};
      obs_v = {lut_wen, done, in_ready, busy, dp_hold, err_start, lut_waddr, lut_wdata};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL load_cyc k=%0d: wen/done/rdy/busy/hold/err/addr/data got %h want %h",
                 k, obs_v, exp_v);
      end
    end
    checks++;
    if (k != 32) begin
      errors++;
      $display("FAIL load_timeout: entries got %0d want 32", k);
    end

    // DONE cycle: the checksum result is not yet evaluated.
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_before_eval: chk_err got %b want 0", chk_err);
    end

    in_valid = 1'b0;
    start    = start_in_done;
    tick();
    start    = 1'b0;
    exp_v = {5'b00000, start_in_done, last_a, last_d};
    obs_v = {lut_wen, done, in_ready, busy, dp_hold, err_start, lut_waddr, lut_wdata};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL idle_after_done: got %h want %h", obs_v, exp_v);
    end

`ifdef CONSMAX_LUT_CHK_EN
    exp_chk = (chk != SUM_OK);
`else
    exp_chk = 1'b0;
`endif
    checks++;
    if (chk_err !== exp_chk) begin
      errors++;
      $display("FAIL chk_result: chk_err got %b want %b", chk_err, exp_chk);
    end

    tick();
    checks++;
    if ({busy, dp_hold, err_start, lut_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_stays: busy/hold/err/wen got %b want 0000",
               {busy, dp_hold, err_start, lut_wen});
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (4) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      cfg_chk  = 16'($urandom);
      tick();
      checks++;
      if ({in_ready, lut_wen, done, busy, dp_hold, err_start, chk_err,
           lut_waddr, lut_wdata} !== 28'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0",
                 {in_ready, lut_wen, done, busy, dp_hold, err_start, chk_err,
                  lut_waddr, lut_wdata});
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    rstn     = 1'b1;
    tick();
    checks++;
    if ({busy, in_ready, dp_hold, lut_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: busy/ready/hold/wen got %b want 0000",
               {busy, in_ready, dp_hold, lut_wen});
    end
  endtask

  task automatic test_back_to_back;
    run_load(1'b0, -1, 1'b0, SUM_OK);
  endtask

  task automatic test_stall_toggle;
    run_load(1'b1, -1, 1'b0, SUM_OK);
  endtask

  task automatic test_err_start;
    run_load(1'b0, 12, 1'b1, SUM_OK);
  endtask

  task automatic test_reset_mid_load;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'h1000 + 16'(i);
      tick();
    end
    checks++;
    if ({lut_wen, lut_waddr, lut_wdata} !== {1'b1, 5'd9, 16'h1009}) begin
      errors++;
      $display("FAIL pre_reset_write: wen/addr/data got %h want %h",
               {lut_wen, lut_waddr, lut_wdata}, {1'b1, 5'd9, 16'h1009});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, lut_wen, done, busy, dp_hold, err_start, chk_err,
         lut_waddr, lut_wdata} !== 28'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {in_ready, lut_wen, done, busy, dp_hold, err_start, chk_err,
                lut_waddr, lut_wdata});
    end
    in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    run_load(1'b0, -1, 1'b0, SUM_OK);
  endtask

  task automatic test_checksum;
    run_load(1'b0, -1, 1'b0, SUM_OK + 16'd1);
    repeat (3) tick();
`ifdef CONSMAX_LUT_CHK_EN
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_sticky: chk_err got %b want 1", chk_err);
    end
`else
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_tied: chk_err got %b want 0", chk_err);
    end
`endif
    // The next accepted start must clear the sticky flag (checked at +1).
    run_load(1'b0, -1, 1'b0, SUM_OK);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_toggle();
    test_err_start();
    test_reset_mid_load();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_consmax_lut_loader
`default_nettype wire
